// File: rtl/maxnet_plu.sv
// Sequential Maxnet lateral-inhibition step: one neuron summed or updated per clock.
// Define MAXNET_PLU_ROUND_EN for round-half-up inhibition; otherwise the inhibition term is truncated.
module maxnet_plu #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*W-1:0] a_in,
  input  logic [W-1:0]   eps,
  output logic [N*W-1:0] a_out,
  output logic           done,
  output logic           valid,
  output logic           busy
);

  localparam int SW = W + $clog2(N);
  localparam int PW = SW + W;
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SUM, UPD, DONE} state_t;

  state_t         state_reg;
  logic [IW-1:0]  idx_reg;
  logic [N*W-1:0] cap_reg;
  logic [N*W-1:0] res_reg;
  logic [N*W-1:0] a_out_reg;
  logic [W-1:0]   eps_reg;
  logic [W-1:0]   aj_reg;
  logic [SW-1:0]  sum_reg;
  logic [PW-1:0]  prod_reg;

  logic [W-1:0]   cap_arr [N];
  logic [W-1:0]   cur_a;
  logic [SW-1:0]  diff;
  logic [SW:0]    d_val;
  logic [W-1:0]   new_val;
  logic [N*W-1:0] res_next;
  logic [N-1:0]   nz;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_neuron
      assign cap_arr[gi] = cap_reg[gi*W +: W];
      // Neuron gi is written one UPD cycle after its product was registered.
      assign res_next[gi*W +: W] = (state_reg == UPD && idx_reg == IW'(gi + 1))
                                   ? new_val : res_reg[gi*W +: W];
      assign nz[gi] = |a_out_reg[gi*W +: W];
    end
  endgenerate

  always_comb begin
    cur_a = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_reg == IW'(i)) cur_a = cap_arr[i];
    end
  end

  // S never drops below any captured neuron, so this cannot wrap.
  assign diff = sum_reg - SW'(cur_a);

`ifdef MAXNET_PLU_ROUND_EN
  localparam logic [PW:0] HALF = (PW+1)'(1) << (W - 1);
  logic [PW:0] prod_rnd;
  assign prod_rnd = {1'b0, prod_reg} + HALF;
  assign d_val    = prod_rnd[PW:W];
`else
  assign d_val = {1'b0, prod_reg[PW-1:W]};
`endif

  assign new_val = (d_val >= (SW+1)'(aj_reg)) ? '0 : aj_reg - d_val[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cap_reg   <= '0;
      res_reg   <= '0;
      a_out_reg <= '0;
      eps_reg   <= '0;
      aj_reg    <= '0;
      sum_reg   <= '0;
      prod_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            cap_reg   <= a_in;
            eps_reg   <= eps;
            sum_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= SUM;
          end
        end
        SUM: begin
          sum_reg <= sum_reg + SW'(cur_a);
          if (idx_reg == IW'(N - 1)) begin
            idx_reg   <= '0;
            state_reg <= UPD;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        UPD: begin
          // Multiply is registered; the write-back trails it by one cycle.
          if (idx_reg != IW'(N)) begin
            prod_reg <= PW'(eps_reg) * PW'(diff);
            aj_reg   <= cur_a;
          end
          res_reg <= res_next;
          if (idx_reg == IW'(N)) begin
            a_out_reg <= res_next;
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign a_out = a_out_reg;
  assign done  = (state_reg == DONE);
  assign busy  = (state_reg != IDLE);
  assign valid = (nz != '0) && ((nz & (nz - N'(1))) == '0);

endmodule

// File: tb/tb_maxnet_plu.sv
// Scoreboard bench for maxnet_plu: drivers queue expected results, a monitor checks each done.
module tb_maxnet_plu;
  localparam int N = 4;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [7:0]  eps = '0;
  logic [31:0] a_out;
  logic        done, valid, busy;

  maxnet_plu #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .eps(eps),
    .a_out(a_out), .done(done), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic        v;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  logic [31:0] last_a = '0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got no response, required completion", name);
  endtask

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference Maxnet step from the arithmetic definition.
  function automatic logic [31:0] model(input logic [31:0] a, input int e);
    int s = 0;
    logic [31:0] r = '0;
    for (int j = 0; j < N; j++) s += int'(a[j*W +: W]);
    for (int j = 0; j < N; j++) begin
      int aj = int'(a[j*W +: W]);
      longint p = longint'(e) * longint'(s - aj);
      longint d;
`ifdef MAXNET_PLU_ROUND_EN
      d = (p + 128) / 256;
`else
      d = p / 256;
`endif
      r[j*W +: W] = (d >= aj) ? 8'd0 : 8'(aj - int'(d));
    end
    return r;
  endfunction

  function automatic logic model_valid(input logic [31:0] a);
    int c = 0;
    for (int j = 0; j < N; j++) if (a[j*W +: W] != 0) c++;
    return (c == 1);
  endfunction

  // Monitor: pops one expectation per done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) check("done_single_cycle", done, 0);
      if (done) begin
        exp_t e;
        done_cnt++;
        last_a = a_out;
        $display("txn %0d: cyc=%0d a_out=%h valid=%b", done_cnt, cyc, a_out, valid);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 with nothing pending, required done=0");
        end else begin
          e = sb.pop_front();
          check("a_out", a_out, e.a);
          check("valid", valid, e.v);
          check("latency", cyc - e.issue, 9);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic push_exp(input logic [31:0] ea, input logic ev, input int ic);
    exp_t x;
    x.a = ea;
    x.v = ev;
    x.issue = ic;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail(name);
  endtask

  task automatic issue(input logic [31:0] a, input logic [7:0] e, input logic [31:0] ea,
                       input logic ev, output int ic);
    wait_idle("issue_wait_idle");
    a_in = a;
    eps = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ic = cyc;
    push_exp(ea, ev, ic);
    check("busy_after_start", busy, 1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || busy) fail(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic;
    int base;
    int iter;
    logic conv;
    logic [31:0] cur, nxt, exp1, ra, rb;
    logic [7:0] re;

`ifdef MAXNET_PLU_ROUND_EN
    exp1 = pk(77, 55, 32, 10);
`else
    exp1 = pk(78, 55, 33, 10);
`endif

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", valid, 0);
    check("reset_a_out", a_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(pk(100, 80, 60, 40), 8'd32, exp1, 1'b0, ic);
    drain("drain_basic");
    issue(pk(200, 0, 0, 0), 8'd128, pk(200, 0, 0, 0), 1'b1, ic);
    drain("drain_single");
    issue(pk(10, 200, 200, 200), 8'd255, 32'd0, 1'b0, ic);
    drain("drain_clamp");
    issue(32'd0, 8'd77, 32'd0, 1'b0, ic);
    drain("drain_zero");

    // Second start pulse during UPD must be ignored.
    issue(pk(100, 80, 60, 40), 8'd32, exp1, 1'b0, ic);
    while (cyc < ic + 6) @(negedge clk);
    a_in = 32'hFFFF_FFFF;
    eps = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("drain_ignored_start");
    check("ignored_start_done_count", sb.size(), 0);

    // Reset during SUM aborts the iteration.
    base = done_cnt;
    a_in = pk(5, 6, 7, 8);
    eps = 8'd40;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_a_out", a_out, 0);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_done", done_cnt - base, 0);
    issue(pk(100, 80, 60, 40), 8'd32, exp1, 1'b0, ic);
    drain("drain_after_reset");

    // start held high: back-to-back iterations 11 edges apart.
    ra = pk(90, 30, 20, 10);
    rb = pk(15, 120, 60, 0);
    a_in = ra;
    eps = 8'd64;
    start = 1'b1;
    @(negedge clk);
    ic = cyc;
    a_in = rb;
    push_exp(model(ra, 64), model_valid(model(ra, 64)), ic);
    push_exp(model(rb, 64), model_valid(model(rb, 64)), ic + 11);
    begin
      int t = 0;
      while (cyc < ic + 11 && t < 30) begin
        @(negedge clk);
        t++;
      end
    end
    start = 1'b0;
    drain("drain_held_start");

    // Randomized iterations.
    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      for (int j = 0; j < N; j++) if ($urandom_range(0, 3) == 0) ra[j*W +: W] = 8'd0;
      re = 8'($urandom_range(0, 255));
      nxt = model(ra, int'(re));
      issue(ra, re, nxt, model_valid(nxt), ic);
    end
    drain("drain_random");

    // Iterate to convergence.
    base = done_cnt;
    cur = pk(100, 80, 60, 40);
    iter = 0;
    conv = 1'b0;
    while (!conv && iter < 40) begin
      nxt = model(cur, 32);
      issue(cur, 8'd32, nxt, model_valid(nxt), ic);
      drain("drain_converge");
      cur = nxt;
      conv = model_valid(nxt);
      iter++;
    end
    check("converged", conv, 1);
    check("winner_neuron0", {last_a[31:8] == 24'd0, last_a[7:0] != 8'd0}, 2'b11);
    check("dones_per_iteration", done_cnt - base, iter);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maxnet_plu.md
MAXNET_PLU -- requirements
Module: maxnet_plu

Interface
REQ-001 The block SHALL have parameter N, default 4, the number of neurons (2..16).
REQ-002 The block SHALL have parameter W, default 8, the activation and eps width (unsigned).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request for one Maxnet iteration.
REQ-006 The block SHALL have port a_in, input, N*W, the current activations; neuron j occupies bits [j*W +: W].
REQ-007 The block SHALL have port eps, input, W, the inhibition weight as unsigned fraction eps/2^W.
REQ-008 The block SHALL have port a_out, output, N*W, the updated activations, with the same packing as a_in.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking a_out and valid as fresh.
REQ-010 The block SHALL have port valid, output, 1, set when exactly one a_out neuron is nonzero (winner found).
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The block SHALL implement states IDLE, SUM, UPD and DONE.
REQ-013 IDLE -> SUM SHALL occur on a clock edge with start=1; on that edge a_in and eps SHALL be captured into internal registers, the sum register SHALL be cleared and the index SHALL be set to 0.
REQ-014 In SUM the block SHALL add one captured neuron per cycle (index 0..N-1) into sum S of width W+clog2(N), with no overflow possible.
REQ-015 After N SUM cycles the block SHALL go to UPD with the index reset to 0.
REQ-016 Each UPD cycle SHALL compute, for neuron j=index, p = eps*(S - a_j) at full width and d = p>>W (see REQ-027), then write new_j = (d >= a_j) ? 0 : a_j - d into the result register.
REQ-017 S SHALL stay frozen during UPD, so every neuron uses the pre-iteration values (synchronous Maxnet update).
REQ-018 After N UPD cycles the block SHALL enter DONE for exactly one cycle.
REQ-019 In DONE the block SHALL assert done=1 and present the result register on a_out; valid SHALL be evaluated from that register and be stable in the same cycle.
REQ-020 From DONE the block SHALL return to IDLE.
REQ-021 The latency from the start-sampling edge to done high SHALL be 2N+1 cycles (9 for N=4).
REQ-022 a_out and valid SHALL hold their values from DONE until the next DONE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 start held high continuously SHALL launch a new iteration on the edge after DONE, with no idle gap beyond the IDLE cycle.
REQ-025 An all-zero a_in SHALL produce a_out=0 and valid=0.

Reset
REQ-026 rst_n=0 SHALL, asynchronously and at any point including mid-SUM or mid-UPD, force IDLE, set a_out, S, the index and the captured registers to 0, and drive done=0, valid=0 and busy=0; the aborted iteration SHALL produce no done.

Configuration
REQ-027 With macro MAXNET_PLU_ROUND_EN defined, d SHALL equal (p + 2^(W-1)) >> W (round half up); when it is undefined, d SHALL equal p >> W (truncate); all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL check: N=4, W=8, eps=32, a_in={100,80,60,40} (neuron0..3), start pulse -> done after 9 cycles, a_out={78,55,33,10} truncated or {77,55,32,10} with ROUND_EN, valid=0.
REQ-029 The bench SHALL check: a_in={200,0,0,0}, eps=128 -> a_out={200,0,0,0}, valid=1, done a single-cycle pulse.
REQ-030 The bench SHALL check the clamp: a_in={10,200,200,200}, eps=255 -> a_out={0,0,0,0}, valid=0.
REQ-031 The bench SHALL check: a second start pulse mid-UPD -> ignored, exactly one done, result equal to the first iteration's.
REQ-032 The bench SHALL check: rst_n low for 1 cycle during SUM -> immediate busy=0, a_out=0, no done; a new start then completes normally in 9 cycles.
REQ-033 The bench SHALL check: iterating a_in=a_out from {100,80,60,40} with eps=32 until valid=1 -> converges with neuron0 as sole nonzero, and done is seen once per iteration.
